// File: rtl/toggle_counter.sv
// Modulo-MOD counter built from T flip-flops: q[i] <= q[i] ^ t[i].
// Define TOGGLE_COUNTER_DOWN_EN to add the up port and down counting.
module toggle_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef TOGGLE_COUNTER_DOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] step;
  logic             over;
  logic             term_up;
  logic             term;

  assign over    = ({1'b0, q} >= MODW);
  assign term_up = (q == TOP) || over;
  assign ld_val  = ({1'b0, din} < MODW) ? din : TOP;

  // Up toggles ripple on the AND of all lower ones.
  always_comb begin
    logic c;
    c = 1'b1;
    t_up = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i] = c;
      c = c & q[i];
    end
  end

`ifdef TOGGLE_COUNTER_DOWN_EN
  logic [WIDTH-1:0] t_dn;
  logic             term_dn;

  assign term_dn = (q == '0) || over;

  always_comb begin
    logic c;
    c = 1'b1;
    t_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_dn[i] = c;
      c = c & ~q[i];
    end
  end

  always_comb begin
    step = '0;
    term = 1'b0;
    if (up) begin
      term = term_up;
      step = term_up ? q : t_up;
    end else begin
      term = term_dn;
      step = term_dn ? (q ^ TOP) : t_dn;
    end
  end
`else
  always_comb begin
    term = term_up;
    step = term_up ? q : t_up;
  end
`endif

  always_comb begin
    t  = '0;
    tc = 1'b0;
    if (!rst_n) begin
      t  = '0;
      tc = 1'b0;
    end else if (load) begin
      t = q ^ ld_val;
    end else if (en) begin
      t  = step;
      tc = term;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q ^ t;
  end

  assign qbar = ~q;

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 Parameter WIDTH, default 4, meaning number of toggle stages (counter bits), legal range 2..16.
REQ-002 Parameter MOD, default 10, meaning count modulus, legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; when low, all toggles zero (hold).
REQ-006 load  input  1  synchronous load request, priority over en.
REQ-007 din  input  WIDTH  load value.
REQ-008 up  input  1  direction, 1 = up, 0 = down (present only with TOGGLE_COUNTER_DOWN_EN).
REQ-009 t  output  WIDTH  combinational per-bit toggle vector applied at the next edge.
REQ-010 q  output  WIDTH  registered count.
REQ-011 qbar  output  WIDTH  always bitwise complement of q.
REQ-012 tc  output  1  combinational terminal-count flag.

Function
REQ-013 Every bit SHALL update only as q[i] <= q[i] ^ t[i]; no other write path to q exists except reset.
REQ-014 load=1: t SHALL equal q ^ L, where L = din if din < MOD, else MOD-1 (clamp); q = L after one edge.
REQ-015 load=0, en=0: t SHALL be all zeros; q holds.
REQ-016 Up count, q < MOD-1: t[0]=1, t[i] = AND of q[i-1:0] for i>0; q increments by 1 per edge.
REQ-017 Up count, q = MOD-1: t SHALL equal q (wrap to 0 next edge).
REQ-018 Down count, q > 0: t[0]=1, t[i] = AND of ~q[i-1:0]; q decrements by 1 per edge.
REQ-019 Down count, q = 0: t SHALL equal q ^ (MOD-1) (wrap to MOD-1 next edge).
REQ-020 q >= MOD (reachable only via unclamped external corruption) SHALL be treated as terminal: up wraps to 0, down loads MOD-1.
REQ-021 tc SHALL be 1 iff load=0, en=1, and q is at terminal (MOD-1 up, 0 down); tc marks the cycle whose edge wraps.
REQ-022 Latency: any change of en/load/din/up affects t in the same cycle and q at the next rising edge.
REQ-023 Simultaneous load and en: load wins, tc=0.
REQ-024 Direction change takes effect on the next edge with no skipped or repeated value.
REQ-025 qbar SHALL equal ~q at all times, including during reset.

Reset
REQ-026 rst_n=0 SHALL force q=0, qbar=all ones immediately, independent of clk.
REQ-027 While rst_n=0, t SHALL be 0 and tc SHALL be 0.
REQ-028 Reset assertion mid-count SHALL abandon the count; first edge after release counts from 0.

Configuration
REQ-029 Macro TOGGLE_COUNTER_DOWN_EN: defined -> up port exists and REQ-018/019 apply when up=0.
REQ-030 Not defined -> no up port, counter is up-only; REQ-018/019 logic absent; behaviour equals up=1 permanently.

Verification
REQ-031 Reset release, en=1, WIDTH=4, MOD=10, 12 edges -> q = 1..9,0,1,2; tc=1 only while q=9.
REQ-032 q=7 (binary 0111), en=1 up -> t=1111 that cycle; q=8 next edge; qbar=0111.
REQ-033 load=1, din=13 with MOD=10 -> q=9 next edge; load=1, din=4 together with en=1 -> q=4, tc=0.
REQ-034 en=0 for 5 edges at q=3 -> t=0000, q stays 3, tc=0.
REQ-035 (DOWN_EN) up=0 from q=1 -> q=0 (tc=1), then 9, 8; toggle up=1 at q=8 -> q=9 next edge.
REQ-036 rst_n pulsed low between edges at q=6 -> q=0, qbar=1111 immediately, t=0, tc=0; after release counts 1,2.
